// File: rtl/ndc_raster_map_if.sv
// ndc_raster_map_if: point-in / raster-index-out stream bundle for ndc_raster_map
interface ndc_raster_map_if #(
  parameter int COORD_W = 11
);
  logic [1:0][15:0] ndc_pt;
  logic [COORD_W-1:0] img_width, img_height, raster_x, raster_y;
  logic in_valid, in_ready, out_of_range, out_valid, out_ready;
  modport master (
    output ndc_pt, img_width, img_height, in_valid, out_ready,
    input in_ready, raster_x, raster_y, out_of_range, out_valid
  );
  modport slave (
    input ndc_pt, img_width, img_height, in_valid, out_ready,
    output in_ready, raster_x, raster_y, out_of_range, out_valid
  );
endinterface

// File: rtl/ndc_raster_map.sv
// ndc_raster_map: normalised f16 point -> integer raster indices, 3-stage valid/ready pipeline
module ndc_raster_map #(
  parameter int COORD_W = 11
) (
  input logic clk,
  input logic rst,
  ndc_raster_map_if.slave bus
);
  localparam int PW = 11 + COORD_W;
  typedef enum logic [1:0] {K_ZERO, K_BAD, K_GE1, K_NORM} kind_t;
  logic s1_valid, s2_valid, en1, en2, en3;
  kind_t s1_kind [2];
  kind_t s2_kind [2];
  logic [4:0] s1_e [2];
  logic [4:0] s2_e [2];
  logic [10:0] s1_sig [2];
  logic [COORD_W-1:0] s1_d [2];
  logic [COORD_W-1:0] s2_d [2];
  logic [COORD_W-1:0] i3 [2];
  logic [PW-1:0] s2_p [2];
  logic [1:0] f3;
  assign en3 = !bus.out_valid || bus.out_ready;
  assign en2 = !s2_valid || en3;
  assign en1 = !s1_valid || en2;
  assign bus.in_ready = en1;
  // Subnormals collapse to zero; any negative or NaN is invalid; e>=15 means value >= 1.0 (incl. +Inf)
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (en1) s1_valid <= bus.in_valid;
    if (en1) begin
      s1_d[0] <= bus.img_width;
      s1_d[1] <= bus.img_height;
      for (int c = 0; c < 2; c++) begin
        s1_e[c] <= bus.ndc_pt[c][14:10];
        s1_sig[c] <= {1'b1, bus.ndc_pt[c][9:0]};
        s1_kind[c] <= bus.ndc_pt[c][14:10] == 5'd0 ? K_ZERO :
                      (bus.ndc_pt[c][15] || (bus.ndc_pt[c][14:10] == 5'd31 && bus.ndc_pt[c][9:0] != 10'd0)) ? K_BAD :
                      bus.ndc_pt[c][14:10] >= 5'd15 ? K_GE1 : K_NORM;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else if (en2) s2_valid <= s1_valid;
    if (en2) begin
      for (int c = 0; c < 2; c++) begin
        s2_p[c] <= PW'(s1_sig[c]) * PW'(s1_d[c]);
        s2_e[c] <= s1_e[c];
        s2_kind[c] <= s1_kind[c];
        s2_d[c] <= s1_d[c];
      end
    end
  end
  // value = sig * 2^(e-25), so floor(value*D) is the exact product shifted right by 25-e
  always_comb begin
    f3 = 2'b00;
    for (int c = 0; c < 2; c++) begin
      i3[c] = s2_d[c] == '0 ? '0 :
              s2_kind[c] == K_NORM ? COORD_W'(s2_p[c] >> (5'd25 - s2_e[c])) :
              s2_kind[c] == K_GE1 ? s2_d[c] - COORD_W'(1) : '0;
      f3[c] = s2_d[c] == '0 || s2_kind[c] == K_BAD || s2_kind[c] == K_GE1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.raster_x <= '0;
      bus.raster_y <= '0;
      bus.out_of_range <= 1'b0;
    end else if (en3) begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.raster_x <= i3[0];
        bus.raster_y <= s2_d[1] == '0 ? '0 : s2_d[1] - COORD_W'(1) - i3[1];
        bus.out_of_range <= |f3;
      end
    end
  end
endmodule

// File: tb/tb_ndc_raster_map.sv
// tb_ndc_raster_map: directed vectors checked against a real-valued model of the raster mapping
module tb_ndc_raster_map;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ndc_raster_map_if bus ();
  ndc_raster_map dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {int x; int y; bit o; bit lit; int lx; int ly; bit lo;} exp_t;
  exp_t q[$];
  int n = 0, bad = 0, emitted = 0;
  bit hold_v = 0, saw_block = 0;
  logic [22:0] hold;
  bit cur_lit = 0, cur_lo = 0;
  int cur_lx = 0, cur_ly = 0;

  task automatic check(input string name, input int act, input int exp);
    n++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor(value*D) from the decoded real value, with invalid inputs clamped and flagged
  function automatic void coord(input logic [15:0] h, input int d, output int i, output bit f);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    real v;
    i = 0;
    f = 0;
    if (d == 0) f = 1;
    else if (e == 0) i = 0;
    else if (e == 31 && m != 0) f = 1;
    else if (h[15]) f = 1;
    else if (e >= 15) begin i = d - 1; f = 1; end
    else begin
      v = real'(1024 + m) / real'(1 << (25 - e));
      i = int'($floor(v * real'(d)));
    end
  endfunction

  function automatic exp_t model(input logic [1:0][15:0] pt, input int w, input int h);
    exp_t r;
    int ix, iy;
    bit fx, fy;
    coord(pt[0], w, ix, fx);
    coord(pt[1], h, iy, fy);
    r.x = ix;
    r.y = h == 0 ? 0 : h - 1 - iy;
    r.o = fx | fy;
    r.lit = 0; r.lx = 0; r.ly = 0; r.lo = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_payload", int'({bus.raster_x, bus.raster_y, bus.out_of_range}), int'(hold));
      end
      if (bus.out_valid && bus.out_ready) begin : pop
        exp_t ex;
        emitted++;
        check("queue_nonempty", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          ex = q.pop_front();
          check("model_x", int'(bus.raster_x), ex.x);
          check("model_y", int'(bus.raster_y), ex.y);
          check("model_oor", int'(bus.out_of_range), int'(ex.o));
          if (ex.lit) begin
            check("lit_x", int'(bus.raster_x), ex.lx);
            check("lit_y", int'(bus.raster_y), ex.ly);
            check("lit_oor", int'(bus.out_of_range), int'(ex.lo));
          end
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold = {bus.raster_x, bus.raster_y, bus.out_of_range};
      if (bus.in_valid && !bus.in_ready) saw_block = 1;
      if (bus.in_valid && bus.in_ready) begin : push
        exp_t r;
        r = model(bus.ndc_pt, int'(bus.img_width), int'(bus.img_height));
        r.lit = cur_lit; r.lx = cur_lx; r.ly = cur_ly; r.lo = cur_lo;
        q.push_back(r);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input int w, input int h,
                      input bit lit = 0, input int lx = 0, input int ly = 0, input bit lo = 0);
    bit ok = 0;
    bus.ndc_pt = {y, x};
    bus.img_width = 11'(w);
    bus.img_height = 11'(h);
    bus.in_valid = 1'b1;
    cur_lit = lit; cur_lx = lx; cur_ly = ly; cur_lo = lo;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    check("accept_in_time", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || bus.out_valid) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_in_time", int'(k < 100), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat, e0;
    time t0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ndc_pt = '0;
    bus.img_width = '0;
    bus.img_height = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_x", int'(bus.raster_x), 0);
    check("rst_y", int'(bus.raster_y), 0);
    check("rst_oor", int'(bus.out_of_range), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    send(16'h3800, 16'h3800, 320, 240, 1, 160, 119, 0);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    drain();
    t0 = $time;
    send(16'h0000, 16'h8000, 320, 240, 1, 0, 239, 0);
    send(16'h0001, 16'h03FF, 320, 240, 1, 0, 239, 0);
    send(16'h3C00, 16'h3BFF, 320, 240, 1, 319, 0, 1);
    send(16'h3BFF, 16'h0000, 320, 240, 1, 319, 239, 0);
    send(16'hB400, 16'h7E00, 320, 240, 1, 0, 239, 1);
    send(16'h7C00, 16'h3400, 320, 240, 1, 319, 179, 1);
    check("throughput_cycles", int'(($time - t0) / 10), 6);
    bus.in_valid = 1'b0;
    drain();
    e0 = emitted;
    fork
      begin
        send(16'h3A00, 16'h2E66, 640, 480);
        send(16'h3800, 16'h3800, 0, 240, 1, 0, 119, 1);
        send(16'h3555, 16'h3555, 320, 240);
        send(16'h2000, 16'h3B00, 100, 200);
        send(16'h3BFF, 16'h3BFF, 2047, 2047);
        send(16'h0400, 16'h3C01, 1, 1, 1, 0, 0, 1);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stream_emitted", emitted - e0, 6);
    check("in_ready_dropped", int'(saw_block), 1);
    bus.out_ready = 1'b0;
    send(16'h3800, 16'h3400, 320, 240);
    send(16'h3400, 16'h3800, 320, 240);
    send(16'h3A00, 16'h3A00, 320, 240);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_x", int'(bus.raster_x), 0);
    check("flush_y", int'(bus.raster_y), 0);
    check("flush_oor", int'(bus.out_of_range), 0);
    rst = 1'b0;
    check("flush_in_ready", int'(bus.in_ready), 1);
    e0 = emitted;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_flush_emitted", emitted - e0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
